// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM control-word pipeline: control-word field positions,
// the bubble word, special register numbers and forwarding select codes.
package arm_pipe_pkg;

   localparam int CW_WIDTH = 16;
   localparam int RA_WIDTH = 4;

   // Bit positions inside the 16-bit decoder control word
   localparam int CW_BL       = 11;
   localparam int CW_NZCV     = 10;
   localparam int CW_PCSRC    = 3;
   localparam int CW_MEMWRITE = 2;
   localparam int CW_REGWRITE = 1;
   localparam int CW_MEMTOREG = 0;

   localparam logic [CW_WIDTH-1:0] CW_BUBBLE = '0;

   localparam int LINK_REG = 14;
   localparam int PC_REG   = 15;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_e;

endpackage

// File: rtl/arm_hazard_unit.sv
// Combinational hazard resolution: load-use and flag-use stalls, taken-branch flush
// and operand forwarding selects for the ID-stage instruction.
module arm_hazard_unit
   import arm_pipe_pkg::*;
#(
   parameter int RA_W = RA_WIDTH
) (
   input  logic            ex_load,
   input  logic            ex_nzcv,
   input  logic            ex_pcsrc,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            mem_regwrite,
   input  logic            mem_memtoreg,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            wb_regwrite,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            id_cond,
   input  logic [RA_W-1:0] id_rn,
   input  logic [RA_W-1:0] id_rm,
   input  logic            id_rn_use,
   input  logic            id_rm_use,
   output logic            stall_f,
   output logic            stall_d,
   output logic            flush_d,
   output logic            ex_bubble,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   logic lu;
   logic fh;

   // A loaded value is only available from WB, so MEM forwards ALU results only; r15 never forwards.
   function automatic fwd_e fwd_select(input logic [RA_W-1:0] r, input logic used);
      if (!used || r == RA_W'(PC_REG))
         return FWD_RF;
      else if (mem_regwrite && !mem_memtoreg && mem_rd == r)
         return FWD_MEM;
      else if (wb_regwrite && wb_rd == r)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      // NOTE: every output gets a default first so no path can leave one unassigned (no latch).
      lu        = 1'b0;
      fh        = 1'b0;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      flush_d   = 1'b0;
      ex_bubble = 1'b0;

      lu = ex_load && ((id_rn_use && id_rn == ex_rd) || (id_rm_use && id_rm == ex_rd));
      fh = id_cond && ex_nzcv;

      // A taken branch discards the ID instruction anyway, so holding it would be pointless.
      flush_d   = ex_pcsrc;
      stall_f   = (lu || fh) && !ex_pcsrc;
      stall_d   = stall_f;
      ex_bubble = lu || fh || ex_pcsrc;
   end

   assign fwd_a = fwd_select(id_rn, id_rn_use);
   assign fwd_b = fwd_select(id_rm, id_rm_use);

endmodule

// File: rtl/arm_ctrl_pipe.sv
// Control-word stage registers ID/EX, EX/MEM and MEM/WB with hazard handling; the
// ID/EX register takes a bubble whenever the hazard unit stalls or flushes.
module arm_ctrl_pipe
   import arm_pipe_pkg::*;
#(
   parameter int CW_W = CW_WIDTH,
   parameter int RA_W = RA_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CW_W-1:0] id_cw,
   input  logic            id_cond,
   input  logic [RA_W-1:0] id_rn,
   input  logic [RA_W-1:0] id_rm,
   input  logic            id_rn_use,
   input  logic            id_rm_use,
   input  logic [RA_W-1:0] id_rd,
   output logic [CW_W-1:0] ex_cw,
   output logic [RA_W-1:0] ex_rd,
   output logic            mem_memwrite,
   output logic            mem_regwrite,
   output logic            mem_memtoreg,
   output logic [RA_W-1:0] mem_rd,
   output logic            wb_regwrite,
   output logic            wb_memtoreg,
   output logic [RA_W-1:0] wb_rd,
   output logic            stall_f,
   output logic            stall_d,
   output logic            flush_d,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   logic ex_bubble;

   arm_hazard_unit #(.RA_W(RA_W)) u_hazard (
      .ex_load      (ex_cw[CW_REGWRITE] & ex_cw[CW_MEMTOREG]),
      .ex_nzcv      (ex_cw[CW_NZCV]),
      .ex_pcsrc     (ex_cw[CW_PCSRC]),
      .ex_rd        (ex_rd),
      .mem_regwrite (mem_regwrite),
      .mem_memtoreg (mem_memtoreg),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .id_cond      (id_cond),
      .id_rn        (id_rn),
      .id_rm        (id_rm),
      .id_rn_use    (id_rn_use),
      .id_rm_use    (id_rm_use),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .ex_bubble    (ex_bubble),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   // NOTE: asynchronous reset clears every stage at once, so no pending write outlives it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_cw        <= CW_BUBBLE;
         ex_rd        <= '0;
         mem_memwrite <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_rd       <= '0;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 1'b0;
         wb_rd        <= '0;
      end else begin
         // NOTE: non-blocking updates let every stage sample its predecessor's old value.
         if (ex_bubble) begin
            ex_cw <= CW_BUBBLE;
            ex_rd <= '0;
         end else begin
            ex_cw <= id_cw;
            ex_rd <= id_cw[CW_BL] ? RA_W'(LINK_REG) : id_rd;
         end
         mem_memwrite <= ex_cw[CW_MEMWRITE];
         mem_regwrite <= ex_cw[CW_REGWRITE];
         mem_memtoreg <= ex_cw[CW_MEMTOREG];
         mem_rd       <= ex_rd;
         wb_regwrite  <= mem_regwrite;
         wb_memtoreg  <= mem_memtoreg;
         wb_rd        <= mem_rd;
      end
   end

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// Self-checking bench for arm_ctrl_pipe: directed hazard scenarios plus random traffic,
// all compared every cycle against an in-flight instruction model.
module tb_arm_ctrl_pipe;

   localparam logic [15:0] LDR_CW = 16'h0103;
   localparam logic [15:0] ADD_CW = 16'h0042;
   localparam logic [15:0] SUB_CW = 16'h0022;
   localparam logic [15:0] STR_CW = 16'h0104;
   localparam logic [15:0] B_CW   = 16'h0008;
   localparam logic [15:0] BL_CW  = 16'h080A;
   localparam logic [15:0] CMP_CW = 16'h0400;
   localparam logic [15:0] LDRPC  = 16'h000B;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] id_cw;
   logic        id_cond;
   logic [3:0]  id_rn, id_rm, id_rd;
   logic        id_rn_use, id_rm_use;
   logic [15:0] ex_cw;
   logic [3:0]  ex_rd, mem_rd, wb_rd;
   logic        mem_memwrite, mem_regwrite, mem_memtoreg;
   logic        wb_regwrite, wb_memtoreg;
   logic        stall_f, stall_d, flush_d;
   logic [1:0]  fwd_a, fwd_b;

   int vectors     = 0;
   int miscompares = 0;

   arm_ctrl_pipe dut (
      .clk          (clk),
      .reset        (reset),
      .id_cw        (id_cw),
      .id_cond      (id_cond),
      .id_rn        (id_rn),
      .id_rm        (id_rm),
      .id_rn_use    (id_rn_use),
      .id_rm_use    (id_rm_use),
      .id_rd        (id_rd),
      .ex_cw        (ex_cw),
      .ex_rd        (ex_rd),
      .mem_memwrite (mem_memwrite),
      .mem_regwrite (mem_regwrite),
      .mem_memtoreg (mem_memtoreg),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_memtoreg  (wb_memtoreg),
      .wb_rd        (wb_rd),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   always #5 clk = ~clk;

   // In-flight instructions by age: 0 = in EX, 1 = in MEM, 2 = in WB.
   typedef struct packed {
      logic [15:0] cw;
      logic [3:0]  rd;
   } instr_t;
   instr_t pipe [3];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic writes(input instr_t i);
      return i.cw[1];
   endfunction

   function automatic logic m_load_use();
      logic is_load = pipe[0].cw[1] && pipe[0].cw[0];
      return is_load && ((id_rn_use && id_rn == pipe[0].rd) || (id_rm_use && id_rm == pipe[0].rd));
   endfunction

   function automatic logic m_hazard();
      return m_load_use() || (id_cond && pipe[0].cw[10]);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [3:0] r, input logic used);
      if (!used || r == 4'd15) return 2'd0;
      if (writes(pipe[1]) && !pipe[1].cw[0] && pipe[1].rd == r) return 2'd1;
      if (writes(pipe[2]) && pipe[2].rd == r) return 2'd2;
      return 2'd0;
   endfunction

   task automatic compare_all();
      logic flush = pipe[0].cw[3];
      logic stall = m_hazard() && !flush;
      check("ex_cw", ex_cw, pipe[0].cw);
      check("ex_rd", ex_rd, pipe[0].rd);
      check("mem_memwrite", mem_memwrite, pipe[1].cw[2]);
      check("mem_regwrite", mem_regwrite, pipe[1].cw[1]);
      check("mem_memtoreg", mem_memtoreg, pipe[1].cw[0]);
      check("mem_rd", mem_rd, pipe[1].rd);
      check("wb_regwrite", wb_regwrite, pipe[2].cw[1]);
      check("wb_memtoreg", wb_memtoreg, pipe[2].cw[0]);
      check("wb_rd", wb_rd, pipe[2].rd);
      check("stall_f", stall_f, stall);
      check("stall_d", stall_d, stall);
      check("flush_d", flush_d, flush);
      check("fwd_a", fwd_a, m_fwd(id_rn, id_rn_use));
      check("fwd_b", fwd_b, m_fwd(id_rm, id_rm_use));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) pipe[i] = '0;
   endtask

   // Called just after a rising edge, while the ID inputs that edge sampled are still applied.
   task automatic model_advance();
      logic squash;
      if (!reset) begin
         model_clear();
         return;
      end
      squash  = pipe[0].cw[3] || m_hazard();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (squash) pipe[0] = '0;
      else        pipe[0] = '{cw: id_cw, rd: (id_cw[11] ? 4'd14 : id_rd)};
   endtask

   task automatic drive(input logic [15:0] cw, input logic cond, input logic [3:0] rn,
                        input logic [3:0] rm, input logic rnu, input logic rmu, input logic [3:0] rd);
      @(posedge clk);
      model_advance();
      @(negedge clk);
      id_cw = cw; id_cond = cond; id_rn = rn; id_rm = rm;
      id_rn_use = rnu; id_rm_use = rmu; id_rd = rd;
      #1 compare_all();
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) drive(16'h0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
   endtask

   function automatic logic [3:0] rand_reg();
      return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      id_cw = '0; id_cond = 1'b0; id_rn = '0; id_rm = '0;
      id_rn_use = 1'b0; id_rm_use = 1'b0; id_rd = '0;
      model_clear();
      repeat (2) @(negedge clk);
      #1 compare_all();
      reset = 1'b1;

      // Idle after reset
      nop(3);
      check("idle_ex_cw", ex_cw, 16'h0000);
      check("idle_stall_f", stall_f, 1'b0);
      check("idle_flush_d", flush_d, 1'b0);

      // Load-use: one stall cycle, then a bubble in EX, then WB forwarding of the load
      drive(LDR_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1);
      drive(ADD_CW, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 4'd3);
      check("lu_stall_f", stall_f, 1'b1);
      check("lu_stall_d", stall_d, 1'b1);
      drive(ADD_CW, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 4'd3);
      check("lu_bubble_ex_cw", ex_cw, 16'h0000);
      check("lu_stall_once", stall_f, 1'b0);
      drive(ADD_CW, 1'b0, 4'd1, 4'd5, 1'b1, 1'b0, 4'd6);
      check("lu_fwd_a_wb", fwd_a, 2'b10);

      // ALU forwarding from MEM, then from WB, and r15 never forwards
      nop(3);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2);
      nop(1);
      drive(SUB_CW, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 4'd7);
      check("fwd_a_mem", fwd_a, 2'b01);
      check("fwd_b_mem", fwd_b, 2'b01);
      nop(3);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2);
      nop(2);
      drive(SUB_CW, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 4'd7);
      check("fwd_a_wb", fwd_a, 2'b10);
      check("fwd_b_wb", fwd_b, 2'b10);
      nop(3);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15);
      nop(1);
      drive(SUB_CW, 1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 4'd7);
      check("fwd_a_r15", fwd_a, 2'b00);

      // Taken branch flush, and flush winning over a simultaneous load-use stall
      nop(3);
      drive(B_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3);
      check("br_flush_d", flush_d, 1'b1);
      nop(1);
      check("br_bubble_ex_cw", ex_cw, 16'h0000);
      nop(3);
      drive(LDRPC, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
      drive(ADD_CW, 1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 4'd5);
      check("br_lu_flush_d", flush_d, 1'b1);
      check("br_lu_stall_f", stall_f, 1'b0);
      check("br_lu_stall_d", stall_d, 1'b0);

      // BL writes the link register, visible in WB three cycles after ID
      nop(3);
      drive(BL_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
      nop(1);
      check("bl_ex_rd", ex_rd, 4'd14);
      nop(2);
      check("bl_wb_rd", wb_rd, 4'd14);
      check("bl_wb_regwrite", wb_regwrite, 1'b1);

      // Flag hazard: CMP followed by a conditional instruction
      nop(3);
      drive(CMP_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      drive(ADD_CW, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3);
      check("fh_stall_f", stall_f, 1'b1);
      drive(ADD_CW, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3);
      check("fh_stall_once", stall_f, 1'b0);
      check("fh_bubble_ex_cw", ex_cw, 16'h0000);

      // Asynchronous reset with writes pending in MEM and WB
      nop(3);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3);
      drive(ADD_CW, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
      nop(2);
      check("pre_rst_mem_regwrite", mem_regwrite, 1'b1);
      check("pre_rst_wb_regwrite", wb_regwrite, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("rst_mem_regwrite", mem_regwrite, 1'b0);
      check("rst_wb_regwrite", wb_regwrite, 1'b0);
      check("rst_ex_cw", ex_cw, 16'h0000);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Random traffic biased toward hazards on a few registers
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] cw;
         case ($urandom_range(0, 7))
            0: cw = 16'h0000;
            1: cw = LDR_CW;
            2: cw = ADD_CW;
            3: cw = B_CW;
            4: cw = CMP_CW;
            5: cw = BL_CW;
            6: cw = STR_CW;
            default: cw = 16'($urandom);
         endcase
         drive(cw, ($urandom_range(0, 3) == 0), rand_reg(), rand_reg(),
               1'($urandom), 1'($urandom), rand_reg());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
